// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone bus arbiter with per-cycle ownership and a stall watchdog.
module wb_rr_arbiter #(
  parameter int MASTERS_NUM    = 2,
  parameter int ADR_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [MASTERS_NUM-1:0]           m_cyc_i,
  input  logic [MASTERS_NUM-1:0]           m_stb_i,
  input  logic [MASTERS_NUM*ADR_WIDTH-1:0] m_adr_i,
  output logic [MASTERS_NUM-1:0]           m_ack_o,
  output logic [MASTERS_NUM-1:0]           m_err_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic [ADR_WIDTH-1:0]             s_adr_o,
  input  logic                             s_ack_i,
  output logic [MASTERS_NUM-1:0]           gnt_o,
  output logic                             busy_o
);
  localparam int IW = $clog2(MASTERS_NUM);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, OWN, ERR, WAIT_REL} state_t;
  state_t                 r_state;
  logic [MASTERS_NUM-1:0] r_gnt;
  logic [IW-1:0]          r_last;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          w_win;
  logic [IW-1:0]          w_idx;
  logic                   w_found;
  logic                   w_own;
  logic                   w_stall;
  logic                   w_timeout;
  // Search starts just past the last winner and wraps, giving round-robin fairness.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = r_last;
    for (int i = 0; i < MASTERS_NUM; i++) begin
      w_idx = (w_idx == IW'(MASTERS_NUM - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && m_cyc_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  assign w_own     = r_state == OWN;
  assign s_cyc_o   = w_own & m_cyc_i[r_last];
  assign s_stb_o   = w_own & m_stb_i[r_last];
  assign s_adr_o   = w_own ? m_adr_i[int'(r_last)*ADR_WIDTH +: ADR_WIDTH] : '0;
  assign m_ack_o   = (w_own & s_ack_i) ? r_gnt : '0;
  assign m_err_o   = (r_state == ERR) ? r_gnt : '0;
  assign gnt_o     = r_gnt;
  assign busy_o    = r_state != IDLE;
  assign w_stall   = s_stb_o & ~s_ack_i;
  // An ACK in the would-be timeout cycle clears w_stall, so the transfer completes.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_stall && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= IW'(MASTERS_NUM - 1);
      r_cnt   <= '0;
    end else begin
      r_cnt <= (w_stall && !w_timeout && m_cyc_i[r_last]) ? r_cnt + 1'b1 : '0;
      case (r_state)
        IDLE: if (w_found) begin
          r_state <= OWN;
          r_gnt   <= MASTERS_NUM'(1) << w_win;
          r_last  <= w_win;
        end
        OWN: if (!m_cyc_i[r_last]) begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end else if (w_timeout)
          r_state <= ERR;
        ERR: r_state <= WAIT_REL;
        default: if (!m_cyc_i[r_last]) begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: scenario tasks plus a grant/address scoreboard checked on every slave ACK.
module tb_wb_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 16;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_cyc = '0;
  logic [N-1:0]    m_stb = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N-1:0]    m_ack, m_err, gnt;
  logic            s_cyc, s_stb, s_ack, busy;
  logic [AW-1:0]   s_adr;
  logic            ack_auto = 1'b1;
  logic            ack_man = 1'b0;
  int              checks = 0;
  int              errors = 0;
  logic [N+AW-1:0] exp_q[$];
  logic [N+AW-1:0] e;
  logic [N-1:0]    ack_seen = '0;
  int              beats[N] = '{default: 0};
  int              reps[N] = '{default: 0};

  wb_rr_arbiter #(.MASTERS_NUM(N), .ADR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_adr_i(m_adr),
    .m_ack_o(m_ack), .m_err_o(m_err), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_adr_o(s_adr),
    .s_ack_i(s_ack), .gnt_o(gnt), .busy_o(busy)
  );

  always #5 clk = ~clk;
  assign s_ack = ack_auto ? (s_cyc & s_stb) : ack_man;

  // Scoreboard: every completed slave transfer must match the next expected grant/address.
  always @(negedge clk) begin
    ack_seen = m_ack;
    checks++;
    if ((m_ack & ~gnt) !== '0) begin
      errors++;
      $display("FAIL ack_route: m_ack=%b outside gnt=%b", m_ack, gnt);
    end
    if (s_cyc && s_stb && s_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: gnt=%b adr=%h with nothing expected", gnt, s_adr);
      end else begin
        e = exp_q.pop_front();
        if ({gnt, s_adr} !== e || m_ack !== e[N+AW-1:AW]) begin
          errors++;
          $display("FAIL sb_transfer: gnt=%b adr=%h m_ack=%b, expected gnt=%b adr=%h",
                   gnt, s_adr, m_ack, e[N+AW-1:AW], e[AW-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (ack_seen[k] && beats[k] > 0) begin
        beats[k]--;
        if (beats[k] == 0) begin
          m_cyc[k] = 1'b0;
          m_stb[k] = 1'b0;
        end
      end else if (!m_cyc[k] && reps[k] > 0) begin
        reps[k]--;
        beats[k] = 1;
        m_cyc[k] = 1'b1;
        m_stb[k] = 1'b1;
      end
    end
  endtask

  task automatic req(input int k, input int n, input logic [AW-1:0] a);
    beats[k] = n;
    m_adr[k*AW +: AW] = a;
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      @(negedge clk);
      done = !busy;
      for (int k = 0; k < N; k++) if (beats[k] != 0 || reps[k] != 0) done = 1'b0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: busy=%b still active after 200 cycles, expected idle", busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_missing: %0d transfers outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (gnt !== '0 || s_cyc !== 1'b0 || s_stb !== 1'b0 || s_adr !== '0 || busy !== 1'b0 ||
        m_ack !== '0 || m_err !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b cyc=%b stb=%b adr=%h busy=%b ack=%b err=%b, expected all 0",
               gnt, s_cyc, s_stb, s_adr, busy, m_ack, m_err);
    end
  endtask

  task automatic test_handoff();
    logic [N-1:0] tbl[6] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    exp_q.push_back({2'b10, 16'h1000});
    exp_q.push_back({2'b01, 16'h0000});
    step();
    rst = 1'b0;
    req(1, 1, 16'h1000);
    for (int j = 0; j < 6; j++) begin
      step();
      if (j == 0) req(0, 1, 16'h0000);
      @(negedge clk);
      checks++;
      if (gnt !== tbl[j]) begin
        errors++;
        $display("FAIL handoff_gnt[%0d]: gnt=%b, expected %b", j, gnt, tbl[j]);
      end
      if (j == 0 || j == 3) begin
        checks++;
        if (s_adr !== (j == 0 ? 16'h1000 : 16'h0000)) begin
          errors++;
          $display("FAIL handoff_adr[%0d]: adr=%h, expected %h", j, s_adr, j == 0 ? 16'h1000 : 16'h0000);
        end
      end
    end
    drain();
  endtask

  task automatic test_alternate();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({2'b01, 16'h0A0A});
      exp_q.push_back({2'b10, 16'h0B0B});
    end
    req(0, 1, 16'h0A0A);
    reps[0] = 1;
    req(1, 1, 16'h0B0B);
    reps[1] = 1;
    drain();
  endtask

  task automatic test_block();
    for (int b = 0; b < 3; b++) exp_q.push_back({2'b01, 16'h0C00});
    exp_q.push_back({2'b10, 16'h0D00});
    req(0, 3, 16'h0C00);
    req(1, 1, 16'h0D00);
    for (int j = 0; j < 3; j++) begin
      step();
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01 || m_ack !== 2'b01) begin
        errors++;
        $display("FAIL block_beat[%0d]: gnt=%b m_ack=%b, expected 01/01", j, gnt, m_ack);
      end
    end
    drain();
  endtask

  task automatic test_timeout();
    logic [N-1:0] ee;
    logic         ec;
    ack_auto = 1'b0;
    ack_man = 1'b0;
    req(0, 1, 16'h0E00);
    for (int j = 0; j < 21; j++) begin
      step();
      @(negedge clk);
      ee = (j == 16) ? 2'b01 : 2'b00;
      ec = (j < 16);
      checks++;
      if (m_err !== ee || s_cyc !== ec || gnt !== 2'b01 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout[%0d]: err=%b cyc=%b gnt=%b busy=%b, expected err=%b cyc=%b gnt=01 busy=1",
                 j, m_err, s_cyc, gnt, busy, ee, ec);
      end
    end
    step();
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    beats[0] = 0;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_rel: gnt=%b busy=%b, expected 01/1", gnt, busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: gnt=%b busy=%b, expected 00/0", gnt, busy);
    end
  endtask

  task automatic test_ack_at_limit();
    exp_q.push_back({2'b10, 16'h0F00});
    req(1, 1, 16'h0F00);
    for (int j = 0; j < 21; j++) begin
      step();
      ack_man = (j == 15);
      @(negedge clk);
      checks++;
      if (m_err !== 2'b00) begin
        errors++;
        $display("FAIL late_ack_err[%0d]: err=%b, expected 00", j, m_err);
      end
      if (j == 15) begin
        checks++;
        if (m_ack !== 2'b10) begin
          errors++;
          $display("FAIL late_ack: m_ack=%b, expected 10", m_ack);
        end
      end
    end
    ack_man = 1'b0;
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL late_ack_done: busy=%b pending=%0d, expected 0/0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    req(0, 1, 16'h2222);
    step();
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL mid_pre_gnt: gnt=%b, expected 01", gnt);
    end
    req(1, 1, 16'h3333);
    step();
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || busy !== 1'b0 || m_ack !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: gnt=%b cyc=%b busy=%b ack=%b, expected all 0", gnt, s_cyc, busy, m_ack);
    end
    ack_auto = 1'b1;
    exp_q.push_back({2'b01, 16'h2222});
    exp_q.push_back({2'b10, 16'h3333});
    step();
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL mid_first_gnt: gnt=%b, expected 01", gnt);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_alternate();
    test_block();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, expected completion before 100000");
    $fatal(1);
  end
endmodule
